// File: rtl/tron_pkg.sv
// tron_pkg: shared game/referee state encodings and default match constants
package tron_pkg;
  typedef enum logic [2:0] {
    MENU          = 3'd0,
    ROUND_PAUSED  = 3'd1,
    ROUND_STARTED = 3'd2,
    BLUE_WINS     = 3'd3,
    RED_WINS      = 3'd4
  } game_state_t;
  typedef enum logic [2:0] {IDLE, ARMED, PLAY, ROUND_END, MATCH_END} referee_state_t;
  localparam int WINS_TO_MATCH_DEF = 3;
  localparam int PAUSE_FRAMES_DEF  = 120;
  localparam int SCORE_W_DEF       = 4;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable frame down-counter with a one-cycle done pulse on reaching zero
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done  <= !load && tick && count == W'(1);
      count <= load ? value : (tick && count != '0) ? count - 1'b1 : count;
    end
endmodule

// File: rtl/round_referee.sv
// round_referee: scores rounds from collision flags, paces the post-crash pause and declares the match winner
module round_referee
  import tron_pkg::*;
#(
  parameter int WINS_TO_MATCH = WINS_TO_MATCH_DEF,
  parameter int PAUSE_FRAMES  = PAUSE_FRAMES_DEF,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  game_state_t        Game_State,
  input  logic               frame_tick,
  input  logic               blue_hit,
  input  logic               red_hit,
  output logic               Blue_W,
  output logic               Red_W,
  output logic               Reset_Round,
  output logic [SCORE_W-1:0] blue_score,
  output logic [SCORE_W-1:0] red_score,
  output logic               round_over
);
  localparam int TW = $clog2(PAUSE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WINS_TO_MATCH);
  referee_state_t state, next;
  logic [SCORE_W-1:0] blue_next, red_next;
  logic bw_next, rw_next, rr_next, done;
  frame_timer #(.W(TW)) timer (
    .clk  (Clk),
    .rst  (Reset),
    .load (next == ROUND_END && state != ROUND_END),
    .value(TW'(PAUSE_FRAMES)),
    .tick (frame_tick && state == ROUND_END),
    .done (done)
  );
  always_comb begin
    next      = state;
    blue_next = blue_score;
    red_next  = red_score;
    bw_next   = Blue_W;
    rw_next   = Red_W;
    rr_next   = 1'b0;
    case (state)
      IDLE: begin
        blue_next = '0;
        red_next  = '0;
        next      = Game_State == ROUND_STARTED ? PLAY : IDLE;
      end
      ARMED: next = Game_State == ROUND_STARTED ? PLAY : ARMED;
      PLAY:
        if (Game_State != ROUND_STARTED) next = ARMED;
        else if (frame_tick && (blue_hit || red_hit)) begin
          // a hit on one bike scores for the other; a double hit is a draw
          red_next  = red_score + SCORE_W'(blue_hit && !red_hit && red_score != WIN);
          blue_next = blue_score + SCORE_W'(red_hit && !blue_hit && blue_score != WIN);
          bw_next   = blue_next == WIN;
          rw_next   = red_next == WIN;
          next      = (blue_next == WIN || red_next == WIN) ? MATCH_END : ROUND_END;
        end
      ROUND_END:
        if (done) begin
          next    = ARMED;
          rr_next = 1'b1;
        end
      default: ;
    endcase
    if (Game_State == MENU) begin
      next      = IDLE;
      blue_next = '0;
      red_next  = '0;
      bw_next   = 1'b0;
      rw_next   = 1'b0;
      rr_next   = 1'b0;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state       <= IDLE;
      blue_score  <= '0;
      red_score   <= '0;
      Blue_W      <= 1'b0;
      Red_W       <= 1'b0;
      Reset_Round <= 1'b0;
      round_over  <= 1'b0;
    end else begin
      state       <= next;
      blue_score  <= blue_next;
      red_score   <= red_next;
      Blue_W      <= bw_next;
      Red_W       <= rw_next;
      Reset_Round <= rr_next;
      round_over  <= next == ROUND_END;
    end
endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee: directed and random stimulus scored against a round/match-level model
module tb_round_referee;
  import tron_pkg::*;
  localparam int W  = WINS_TO_MATCH_DEF;
  localparam int P  = PAUSE_FRAMES_DEF;
  localparam int SW = SCORE_W_DEF;
  logic Clk = 0, Reset = 0, ft = 0, bh = 0, rh = 0;
  game_state_t gs = MENU;
  logic Blue_W, Red_W, Reset_Round, round_over;
  logic [SW-1:0] blue_score, red_score;
  round_referee dut (
    .Clk(Clk), .Reset(Reset), .Game_State(gs), .frame_tick(ft), .blue_hit(bh), .red_hit(rh),
    .Blue_W(Blue_W), .Red_W(Red_W), .Reset_Round(Reset_Round),
    .blue_score(blue_score), .red_score(red_score), .round_over(round_over)
  );
  always #5 Clk = ~Clk;
  typedef struct packed {
    logic [SW-1:0] bs, rs;
    logic bw, rw, rr, ro;
  } snap_t;
  typedef struct {
    snap_t s;
    int    cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, fails = 0;
  always @(posedge Clk) cyc <= cyc + 1;
  // match-level model: who is playing, how many frames of pause remain, running scores
  typedef enum {M_IDLE, M_ARMED, M_PLAY, M_PAUSE, M_MATCH} mode_t;
  mode_t mode = M_IDLE;
  int b = 0, r = 0, rem = 0;
  bit bw = 0, rw = 0, pend = 0, rr = 0;
  snap_t m_prev = '0;
  task automatic model(input bit rst_now);
    snap_t s;
    rr = 0;
    if (rst_now || gs == MENU) begin
      mode = M_IDLE; b = 0; r = 0; bw = 0; rw = 0; pend = 0;
    end else if (mode == M_PAUSE && pend) begin
      mode = M_ARMED; rr = 1; pend = 0;
    end else if ((mode == M_IDLE || mode == M_ARMED) && gs == ROUND_STARTED) mode = M_PLAY;
    else if (mode == M_PLAY && gs != ROUND_STARTED) mode = M_ARMED;
    else if (mode == M_PLAY && ft && (bh || rh)) begin
      if (bh && !rh) r++;
      if (rh && !bh) b++;
      bw = b == W;
      rw = r == W;
      if (bw || rw) mode = M_MATCH;
      else begin
        mode = M_PAUSE; rem = P;
      end
    end else if (mode == M_PAUSE && ft) begin
      rem--;
      if (rem == 0) pend = 1;
    end
    s = {SW'(b), SW'(r), bw, rw, rr, mode == M_PAUSE};
    if (s != m_prev) q.push_back('{s, cyc + 1});
    m_prev = s;
  endtask
  task automatic step(input game_state_t g, input logic f, input logic hb, input logic hr, input logic rs = 0);
    @(posedge Clk);
    #2;
    gs = g; ft = f; bh = hb; rh = hr; Reset = rs;
    model(rs);
  endtask
  task automatic tick(input game_state_t g, input logic hb, input logic hr);
    step(g, 1, hb, hr);
    step(g, 0, 0, 0);
  endtask
  initial begin
    snap_t prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge Clk);
      #1;
      cur = {blue_score, red_score, Blue_W, Red_W, Reset_Round, round_over};
      if (cur != prev || (q.size() > 0 && q[0].cyc == cyc)) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, cur, prev);
        end else begin
          e = q.pop_front();
          if (e.s != cur || e.cyc != cyc) begin
            fails++;
            $display("FAIL outputs cyc=%0d got=%h (bs,rs,bw,rw,rr,ro) expected=%h at cyc=%0d", cyc, cur, e.s, e.cyc);
          end
        end
      end
      prev = cur;
    end
  end
  initial begin
    #1 Reset = 1;
    step(MENU, 0, 0, 0);
    // reset in the middle of a pause, with 50 frames left
    step(ROUND_STARTED, 0, 0, 0);
    tick(ROUND_STARTED, 0, 1);
    repeat (P - 50) tick(ROUND_STARTED, 0, 0);
    step(ROUND_STARTED, 0, 0, 0, 1);
    repeat (300) step(ROUND_PAUSED, ft, 0, 0);
    repeat (300) tick(ROUND_PAUSED, 0, 0);
    // blue scores, full pause, then ignored hits
    step(ROUND_STARTED, 0, 0, 0);
    tick(ROUND_STARTED, 0, 1);
    repeat (P + 5) tick(ROUND_STARTED, 0, 0);
    step(ROUND_STARTED, 0, 0, 1);
    step(ROUND_STARTED, 0, 1, 0);
    step(ROUND_PAUSED, 0, 0, 0);
    tick(ROUND_PAUSED, 0, 1);
    tick(ROUND_PAUSED, 1, 0);
    // draw
    step(ROUND_STARTED, 0, 0, 0);
    tick(ROUND_STARTED, 1, 1);
    repeat (P + 5) tick(ROUND_STARTED, 0, 0);
    // abort from PLAY keeps scores, then resume
    repeat (3) step(ROUND_PAUSED, 0, 0, 0);
    step(ROUND_STARTED, 0, 0, 0);
    // blue takes the match
    tick(ROUND_STARTED, 0, 1);
    repeat (P + 3) tick(ROUND_STARTED, 0, 0);
    tick(ROUND_STARTED, 0, 1);
    repeat (20) tick(BLUE_WINS, 1, 1);
    repeat (2 * P) tick(ROUND_STARTED, 0, 0);
    step(MENU, 0, 0, 0);
    step(MENU, 0, 0, 0);
    // randomized play
    for (int i = 0; i < 30000; i++) begin
      game_state_t g;
      logic f;
      int k;
      k = int'($urandom_range(0, 2999));
      g = k < 3 ? MENU : k < 18 ? ROUND_PAUSED : k < 20 ? game_state_t'($urandom_range(0, 4)) : ROUND_STARTED;
      if (mode == M_MATCH) g = ($urandom_range(0, 49) == 0) ? MENU : (bw ? BLUE_WINS : RED_WINS);
      f = $urandom_range(0, 2) == 0;
      if (f) step(g, 1, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, k == 2999);
      else step(g, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, k == 2999);
    end
    repeat (4) step(MENU, 0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations got=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
